// File: rtl/sha256_pkg.sv
// Widths and record types shared by the SHA-256 front end.
package sha256_pkg;
   localparam int SHA256_WORD_W    = 32;
   localparam int SHA256_BLK_WORDS = 16;
   localparam int SHA256_BLK_W     = SHA256_WORD_W * SHA256_BLK_WORDS;
   localparam int SHA256_IDX_W     = $clog2(SHA256_BLK_WORDS);

   typedef logic [SHA256_WORD_W-1:0] word_t;

   typedef struct packed {
      logic [SHA256_BLK_W-1:0] data;
      logic                    first;
      logic                    last;
   } blk_t;

   // Occupancy of the loader: PEND is only reachable with two buffers.
   typedef enum logic [1:0] {
      LD_EMPTY = 2'd0,
      LD_PEND  = 2'd1,
      LD_FULL  = 2'd2
   } ld_state_t;
endpackage

// File: rtl/sha256_block_buf.sv
// One 512-bit block register: indexed word writes, flags latched on word 0,
// and a full flag set on block completion and cleared on hand-off.
module sha256_block_buf
   import sha256_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write,
   input  logic [SHA256_IDX_W-1:0] idx,
   input  logic [SHA256_WORD_W-1:0] word,
   input  logic                    first,
   input  logic                    last,
   input  logic                    fill_done,
   input  logic                    clear,
   output logic [SHA256_BLK_W-1:0] block,
   output logic                    is_first,
   output logic                    is_last,
   output logic                    full
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         block    <= '0;
         is_first <= 1'b0;
         is_last  <= 1'b0;
         full     <= 1'b0;
      end else begin
         if (write) begin
            // Word 0 lands in the most significant slot.
            block[SHA256_BLK_W-1 - SHA256_WORD_W*int'(idx) -: SHA256_WORD_W] <= word;
            if (idx == '0) begin
               is_first <= first;
               is_last  <= last;
            end
         end
         if (clear)
            full <= 1'b0;
         else if (fill_done)
            full <= 1'b1;
      end
   end

endmodule

// File: rtl/sha256_block_loader.sv
// Collects sixteen host words into a block for the SHA-256 core.
// Define SHA256_LOADER_DBUF_EN for a ping-pong pair of block buffers.
module sha256_block_loader
   import sha256_pkg::*;
#(
   parameter int DATA_W = SHA256_WORD_W,
   parameter int WORDS  = SHA256_BLK_WORDS
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         data,
   input  logic                      write_enable,
   input  logic                      first_block,
   input  logic                      last_block,
   output logic                      busy,
   output logic                      overrun,
   output logic [DATA_W*WORDS-1:0]   blk_data,
   output logic                      blk_first,
   output logic                      blk_last,
   output logic                      blk_valid,
   input  logic                      blk_ready
);

`ifdef SHA256_LOADER_DBUF_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif

   logic [SHA256_IDX_W-1:0] wcnt;
   logic                    accept, done, hs;
   logic [NBUF-1:0]         full, wr_sel, rd_sel;
   logic [SHA256_BLK_W-1:0] buf_data  [NBUF];
   logic                    buf_first [NBUF];
   logic                    buf_last  [NBUF];
   blk_t                    out_blk;
   ld_state_t               state, state_next;

   assign accept    = write_enable & ~busy;
   assign done      = accept & (wcnt == SHA256_IDX_W'(WORDS-1));
   assign blk_valid = |(full & rd_sel);
   assign hs        = blk_valid & blk_ready;

   for (genvar g = 0; g < NBUF; g++) begin : g_buf
      sha256_block_buf u_buf (
         .clk       (clk),
         .reset     (reset),
         .write     (accept & wr_sel[g]),
         .idx       (wcnt),
         .word      (data),
         .first     (first_block),
         .last      (last_block),
         .fill_done (done & wr_sel[g]),
         .clear     (hs & rd_sel[g]),
         .block     (buf_data[g]),
         .is_first  (buf_first[g]),
         .is_last   (buf_last[g]),
         .full      (full[g])
      );
   end

`ifdef SHA256_LOADER_DBUF_EN
   logic wr_ptr, rd_ptr;

   // Fill and drain pointers alternate, so blocks leave in fill order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (done) wr_ptr <= ~wr_ptr;
         if (hs)   rd_ptr <= ~rd_ptr;
      end
   end

   assign wr_sel  = wr_ptr ? 2'b10 : 2'b01;
   assign rd_sel  = rd_ptr ? 2'b10 : 2'b01;
   assign out_blk = '{data: buf_data[rd_ptr], first: buf_first[rd_ptr], last: buf_last[rd_ptr]};
`else
   assign wr_sel  = 1'b1;
   assign rd_sel  = 1'b1;
   assign out_blk = '{data: buf_data[0], first: buf_first[0], last: buf_last[0]};
`endif

   assign blk_data  = out_blk.data;
   assign blk_first = out_blk.first;
   assign blk_last  = out_blk.last;

   always_comb begin
      state_next = state;
      case (state)
         LD_EMPTY: if (done) state_next = (NBUF > 1) ? LD_PEND : LD_FULL;
         LD_PEND: begin
            if (done && !hs)
               state_next = LD_FULL;
            else if (hs && !done)
               state_next = LD_EMPTY;
         end
         LD_FULL:  if (hs) state_next = (NBUF > 1) ? LD_PEND : LD_EMPTY;
         default:  state_next = LD_EMPTY;
      endcase
   end

   // busy is registered from the next occupancy so it never depends on blk_ready combinationally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= LD_EMPTY;
         busy    <= 1'b0;
         overrun <= 1'b0;
         wcnt    <= '0;
      end else begin
         state   <= state_next;
         busy    <= (state_next == LD_FULL);
         overrun <= overrun | (write_enable & busy);
         if (accept)
            wcnt <= done ? '0 : wcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sha256_block_loader.sv
// Directed bench for sha256_block_loader; double-buffer steps run when
// SHA256_LOADER_DBUF_EN is defined.
module tb_sha256_block_loader;

`ifdef SHA256_LOADER_DBUF_EN
   localparam bit DBUF = 1'b1;
`else
   localparam bit DBUF = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  data = '0;
   logic         write_enable = 1'b0;
   logic         first_block = 1'b0;
   logic         last_block = 1'b0;
   logic         busy, overrun, blk_first, blk_last, blk_valid;
   logic [511:0] blk_data;
   logic         blk_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   int nvalid = 0;

   sha256_block_loader dut (
      .clk          (clk),
      .reset        (reset),
      .data         (data),
      .write_enable (write_enable),
      .first_block  (first_block),
      .last_block   (last_block),
      .busy         (busy),
      .overrun      (overrun),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance one edge, settle, and count cycles with a block on offer.
   task automatic tick();
      @(posedge clk);
      #1;
      if (blk_valid === 1'b1) nvalid++;
   endtask

   task automatic write_word(input logic [31:0] w, input logic f, input logic l);
      write_enable = 1'b1;
      data         = w;
      first_block  = f;
      last_block   = l;
      tick();
      write_enable = 1'b0;
      first_block  = 1'b0;
      last_block   = 1'b0;
   endtask

   task automatic write_block(input logic [31:0] base, input logic f0, input logic l0,
                              input logic fr, input logic lr, input int n);
      for (int i = 0; i < n; i++)
         write_word(base + 32'(i), (i == 0) ? f0 : fr, (i == 0) ? l0 : lr);
   endtask

   function automatic logic [511:0] exp_blk(input logic [31:0] base);
      logic [511:0] e;
      for (int i = 0; i < 16; i++)
         e[511-32*i -: 32] = base + 32'(i);
      return e;
   endfunction

   initial begin
      logic stable;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_valid", blk_valid, 0);
      chk("rst_first", blk_first, 0);
      chk("rst_last", blk_last, 0);
      chk("rst_data", blk_data, 0);
      reset = 1'b1;
      tick();

      // Basic block with core always ready
      blk_ready = 1'b1;
      write_block(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16);
      chk("b1_valid", blk_valid, 1);
      chk("b1_data", blk_data, exp_blk(32'h0));
      chk("b1_word0", blk_data[511:480], 32'h0000_0000);
      chk("b1_word15", blk_data[31:0], 32'h0000_000F);
      chk("b1_first", blk_first, 1);
      chk("b1_last", blk_last, 1);
      chk("b1_busy", busy, !DBUF);
      tick();
      chk("b1_valid_drop", blk_valid, 0);
      chk("b1_busy_drop", busy, 0);

`ifndef SHA256_LOADER_DBUF_EN
      // Hold under backpressure; a write while busy is dropped
      blk_ready = 1'b0;
      write_block(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 16);
      chk("b2_valid", blk_valid, 1);
      chk("b2_busy", busy, 1);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) write_word(32'hDEAD_BEEF, 1'b1, 1'b1);
         else        tick();
         if (!(blk_valid === 1'b1 && busy === 1'b1 && blk_data === exp_blk(32'h100)))
            stable = 1'b0;
      end
      chk("b2_hold_stable", stable, 1);
      chk("b2_overrun", overrun, 1);
      chk("b2_first", blk_first, 0);
      chk("b2_last", blk_last, 1);
      blk_ready = 1'b1;
      tick();
      chk("b2_valid_drop", blk_valid, 0);
      chk("b2_busy_drop", busy, 0);
      write_block(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 16);
      chk("b2_next_data", blk_data, exp_blk(32'h200));
      chk("b2_overrun_sticky", overrun, 1);
      tick();
`endif

      // Reset mid-block discards the partial words
      blk_ready = 1'b1;
      nvalid = 0;
      write_block(32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 8);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_valid", blk_valid, 0);
      chk("mid_rst_flags", {blk_first, blk_last}, 2'b00);
      chk("mid_rst_data", blk_data, 0);
      tick();
      reset = 1'b1;
      write_block(32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 16);
      chk("b3_data", blk_data, exp_blk(32'h400));
      chk("b3_flags", {blk_first, blk_last}, 2'b11);
      repeat (3) tick();
      chk("b3_block_count", nvalid, 1);

      // Flags only count on word 0
      write_block(32'h500, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      chk("b4_first", blk_first, 0);
      chk("b4_last", blk_last, 0);
      chk("b4_data", blk_data, exp_blk(32'h500));
      tick();

`ifdef SHA256_LOADER_DBUF_EN
      // Three blocks under 40 cycles of backpressure
      blk_ready = 1'b0;
      write_block(32'hA000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 16);
      chk("db_a_busy", busy, 0);
      write_block(32'hB000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      chk("db_ab_busy", busy, 1);
      chk("db_a_out", blk_data, exp_blk(32'hA000_0000));
      repeat (8) tick();
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      chk("db_b_valid", blk_valid, 1);
      chk("db_b_out", blk_data, exp_blk(32'hB000_0000));
      chk("db_busy_fall", busy, 0);
      write_block(32'hC000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16);
      blk_ready = 1'b1;
      tick();
      chk("db_c_out", blk_data, exp_blk(32'hC000_0000));
      chk("db_c_last", blk_last, 1);
      tick();
      chk("db_drain", blk_valid, 0);

      // Completion and hand-off on the same edge
      blk_ready = 1'b0;
      write_block(32'hD000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      write_block(32'hE000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 15);
      blk_ready = 1'b1;
      write_word(32'hE000_000F, 1'b0, 1'b0);
      chk("db_e_valid", blk_valid, 1);
      chk("db_e_out", blk_data, exp_blk(32'hE000_0000));
      tick();
      chk("db_e_drain", blk_valid, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
